// File: rtl/decode_issue.sv
// Issue stage feeding the ALU: decodes one RV32I(+MUL) instruction per handshake,
// reads the register file with writeback bypass, and registers the operands into one output slot.
module decode_issue #(
    parameter int XLEN            = 32,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_l,
    output logic [XLEN-1:0] out_r,
    output logic [4:0]      out_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_branch,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] ZERO  = {XLEN{1'b0}};

    logic [XLEN-1:0] regs_r [0:31];
    logic            accept_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] shamt_s;
    logic [4:0]      dec_ctrl_s;
    logic [XLEN-1:0] dec_l_s;
    logic [XLEN-1:0] dec_r_s;
    logic            dec_we_s;
    logic            dec_branch_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_illegal_s;
    logic [4:0]      dec_rd_s;

    assign in_ready = !out_valid | out_ready;
    assign accept_s = in_valid & in_ready;

    assign opcode_s = in_instr[6:0];
    assign funct3_s = in_instr[14:12];
    assign funct7_s = in_instr[31:25];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign imm_i_s  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_b_s  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign shamt_s  = {27'd0, in_instr[24:20]};

    // Register file: cleared on reset, x0 never written, writeback never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= ZERO;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // rs1 read with same-cycle writeback bypass; x0 is hard zero.
    always_comb begin
        rs1_val_s = ZERO;
        if (rs1_s == 5'd0) begin
            rs1_val_s = ZERO;
        end else if (wb_en && (wb_addr == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = regs_r[rs1_s];
        end
    end

    // rs2 read with same-cycle writeback bypass; x0 is hard zero.
    always_comb begin
        rs2_val_s = ZERO;
        if (rs2_s == 5'd0) begin
            rs2_val_s = ZERO;
        end else if (wb_en && (wb_addr == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = regs_r[rs2_s];
        end
    end

    // Instruction decode into ALU control, operands and side-band flags.
    always_comb begin
        dec_ctrl_s    = 5'd0;
        dec_l_s       = ZERO;
        dec_r_s       = ZERO;
        dec_we_s      = 1'b0;
        dec_branch_s  = 1'b0;
        dec_imm_s     = ZERO;
        dec_illegal_s = 1'b0;
        dec_rd_s      = 5'd0;
        case (opcode_s)
            OPC_OP: begin
                dec_l_s  = rs1_val_s;
                dec_r_s  = rs2_val_s;
                dec_we_s = 1'b1;
                case (funct7_s)
                    7'b0000000: begin
                        case (funct3_s)
                            3'b000:  dec_ctrl_s = 5'd0;
                            3'b111:  dec_ctrl_s = 5'd2;
                            3'b110:  dec_ctrl_s = 5'd3;
                            3'b100:  dec_ctrl_s = 5'd4;
                            3'b001:  dec_ctrl_s = 5'd9;
                            3'b101:  dec_ctrl_s = 5'd8;
                            3'b010:  dec_ctrl_s = 5'd14;
                            3'b011:  dec_ctrl_s = 5'd16;
                            default: dec_illegal_s = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3_s)
                            3'b000:  dec_ctrl_s = 5'd1;
                            3'b101:  dec_ctrl_s = 5'd7;
                            default: dec_illegal_s = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        if (funct3_s == 3'b000) begin
                            dec_ctrl_s = 5'd10;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_l_s  = rs1_val_s;
                dec_r_s  = imm_i_s;
                dec_we_s = 1'b1;
                case (funct3_s)
                    3'b000: dec_ctrl_s = 5'd0;
                    3'b111: dec_ctrl_s = 5'd2;
                    3'b110: dec_ctrl_s = 5'd3;
                    3'b100: dec_ctrl_s = 5'd4;
                    3'b010: dec_ctrl_s = 5'd14;
                    3'b011: dec_ctrl_s = 5'd16;
                    3'b001: begin
                        dec_r_s = shamt_s;
                        if (funct7_s == 7'b0000000) begin
                            dec_ctrl_s = 5'd9;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end
                    3'b101: begin
                        dec_r_s = shamt_s;
                        if (funct7_s == 7'b0000000) begin
                            dec_ctrl_s = 5'd8;
                        end else if (funct7_s == 7'b0100000) begin
                            dec_ctrl_s = 5'd7;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_ctrl_s = 5'd11;
                dec_l_s    = ZERO;
                dec_r_s    = {12'd0, in_instr[31:12]};
                dec_we_s   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl_s = 5'd0;
                dec_l_s    = in_pc;
                dec_r_s    = {in_instr[31:12], 12'd0};
                dec_we_s   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_l_s      = rs1_val_s;
                dec_r_s      = rs2_val_s;
                dec_branch_s = 1'b1;
                dec_imm_s    = imm_b_s;
                case (funct3_s)
                    3'b000:  dec_ctrl_s = 5'd12;
                    3'b001:  dec_ctrl_s = 5'd13;
                    3'b100:  dec_ctrl_s = 5'd14;
                    3'b101:  dec_ctrl_s = 5'd15;
                    3'b110:  dec_ctrl_s = 5'd16;
                    3'b111:  dec_ctrl_s = 5'd17;
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            default: dec_illegal_s = 1'b1;
        endcase

        // An unsupported encoding travels as a neutral bubble flagged illegal.
        if (dec_illegal_s) begin
            dec_ctrl_s   = 5'd0;
            dec_l_s      = ZERO;
            dec_r_s      = ZERO;
            dec_we_s     = 1'b0;
            dec_branch_s = 1'b0;
            dec_imm_s    = ZERO;
        end else begin
            dec_ctrl_s   = dec_ctrl_s;
        end

        if (dec_we_s) begin
            dec_rd_s = in_instr[11:7];
        end else begin
            dec_rd_s = 5'd0;
        end
    end

    // Single output slot: load on accept, drop valid on drain, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_l       <= ZERO;
            out_r       <= ZERO;
            out_ctrl    <= 5'd0;
            out_rd      <= 5'd0;
            out_rd_we   <= 1'b0;
            out_branch  <= 1'b0;
            out_imm     <= ZERO;
            out_pc      <= XLEN'(RESET_PC_UNUSED);
            out_illegal <= 1'b0;
        end else if (accept_s) begin
            out_valid   <= 1'b1;
            out_l       <= dec_l_s;
            out_r       <= dec_r_s;
            out_ctrl    <= dec_ctrl_s;
            out_rd      <= dec_rd_s;
            out_rd_we   <= dec_we_s;
            out_branch  <= dec_branch_s;
            out_imm     <= dec_imm_s;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal_s;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: table of decode vectors plus stall, drain and reset sequences.
module tb_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_l;
    logic [31:0] out_r;
    logic [4:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_branch;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;

    int n_total;
    int n_pass;

    decode_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_branch(out_branch), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [4:0]  ctrl;
        logic [31:0] l;
        logic [31:0] r;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] ctrl, input logic [31:0] l, input logic [31:0] r,
                                input logic [4:0] rd, input logic we, input logic br,
                                input logic [31:0] imm, input logic ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.wb_en = 1'b0; v.wb_addr = 5'd0; v.wb_data = 32'd0;
        v.ctrl = ctrl; v.l = l; v.r = r; v.rd = rd; v.we = we; v.br = br; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t bad(input logic [31:0] instr, input logic [31:0] pc);
        return mk(instr, pc, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        rst = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b1;

        // x8 = F0F0F0F0, x9 = F, x5 = 7, x6 = 3, x1 later via bypass = 80000000
        vecs[0]  = mk(32'h406283B3, 32'h1000, 5'd1, 32'd7, 32'd3, 5'd7, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[1]  = mk(32'hFFF00093, 32'h1004, 5'd0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[1].wb_en = 1'b1; vecs[1].wb_addr = 5'd0; vecs[1].wb_data = 32'hDEADBEEF;
        vecs[2]  = mk(32'h4040D113, 32'h1008, 5'd7, 32'h80000000, 32'd4, 5'd2, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[2].wb_en = 1'b1; vecs[2].wb_addr = 5'd1; vecs[2].wb_data = 32'h80000000;
        vecs[3]  = mk(32'h123451B7, 32'h100C, 5'd11, 32'd0, 32'h00012345, 5'd3, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[4]  = mk(32'h00001217, 32'h0100, 5'd0, 32'h100, 32'h1000, 5'd4, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[5]  = mk(32'hFE20DCE3, 32'h0200, 5'd15, 32'h80000000, 32'd0, 5'd0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0);
        vecs[6]  = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd7, 5'd10), 32'h1010, 5'd2, 32'hF0F0F0F0, 32'hF, 5'd10, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[7]  = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd6, 5'd11), 32'h1014, 5'd3, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[8]  = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd4, 5'd11), 32'h1018, 5'd4, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[9]  = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd1, 5'd11), 32'h101C, 5'd9, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[10] = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd5, 5'd11), 32'h1020, 5'd8, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[11] = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd2, 5'd11), 32'h1024, 5'd14, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[12] = mk(enc_r(7'h00, 5'd9, 5'd8, 3'd3, 5'd11), 32'h1028, 5'd16, 32'hF0F0F0F0, 32'hF, 5'd11, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[13] = mk(enc_r(7'h01, 5'd9, 5'd8, 3'd0, 5'd12), 32'h102C, 5'd10, 32'hF0F0F0F0, 32'hF, 5'd12, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[14] = bad(enc_r(7'h01, 5'd9, 5'd8, 3'd1, 5'd12), 32'h1030);
        vecs[15] = bad(enc_r(7'h20, 5'd9, 5'd8, 3'd7, 5'd12), 32'h1034);
        vecs[16] = mk(enc_i(12'hFF0, 5'd8, 3'd7, 5'd12), 32'h1038, 5'd2, 32'hF0F0F0F0, 32'hFFFFFFF0, 5'd12, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[17] = mk(enc_i(12'h005, 5'd9, 3'd3, 5'd13), 32'h103C, 5'd16, 32'hF, 32'd5, 5'd13, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[18] = mk(enc_i(12'h01F, 5'd9, 3'd1, 5'd14), 32'h1040, 5'd9, 32'hF, 32'h1F, 5'd14, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[19] = bad(enc_i(12'h41F, 5'd9, 3'd1, 5'd14), 32'h1044);
        vecs[20] = mk(enc_i(12'h003, 5'd9, 3'd5, 5'd14), 32'h1048, 5'd8, 32'hF, 32'd3, 5'd14, 1'b1, 1'b0, 32'd0, 1'b0);
        vecs[21] = mk(enc_b(13'h0010, 5'd9, 5'd8, 3'd6), 32'h104C, 5'd16, 32'hF0F0F0F0, 32'hF, 5'd0, 1'b0, 1'b1, 32'h10, 1'b0);
        vecs[22] = bad(enc_b(13'h0010, 5'd9, 5'd8, 3'd2), 32'h1050);
        vecs[23] = bad(32'h0000007F, 32'h1054);
        vecs[24] = mk(enc_b(13'h1000, 5'd0, 5'd0, 3'd0), 32'h1058, 5'd12, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'hFFFFF000, 1'b0);
        vecs[25] = mk(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd15), 32'h105C, 5'd0, 32'd7, 32'd0, 5'd15, 1'b1, 1'b0, 32'd0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_l", out_l, 32'd0);
        chk("reset out_ctrl", {27'd0, out_ctrl}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        #1;

        wb_write(5'd5, 32'h7);
        wb_write(5'd6, 32'h3);
        wb_write(5'd8, 32'hF0F0F0F0);
        wb_write(5'd9, 32'hF);

        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
            wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            @(posedge clk); #1;
            wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
            chk($sformatf("v%0d valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d ctrl", i), {27'd0, out_ctrl}, {27'd0, vecs[i].ctrl});
            chk($sformatf("v%0d l", i), out_l, vecs[i].l);
            chk($sformatf("v%0d r", i), out_r, vecs[i].r);
            chk($sformatf("v%0d rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d rd_we", i), {31'd0, out_rd_we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d branch", i), {31'd0, out_branch}, {31'd0, vecs[i].br});
            chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d pc", i), out_pc, vecs[i].pc);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain valid", {31'd0, out_valid}, 32'd0);

        // Stall with a waiting instruction, then release into back-to-back accepts.
        in_valid = 1'b1; in_instr = 32'h406283B3; in_pc = 32'h2000; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_instr = 32'h123451B7; in_pc = 32'h2004;
        #1;
        chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("stall%0d ctrl", c), {27'd0, out_ctrl}, 32'd1);
            chk($sformatf("stall%0d l", c), out_l, 32'd7);
            chk($sformatf("stall%0d pc", c), out_pc, 32'h2000);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("b2b1 valid", {31'd0, out_valid}, 32'd1);
        chk("b2b1 ctrl", {27'd0, out_ctrl}, 32'd11);
        chk("b2b1 r", out_r, 32'h00012345);
        in_instr = 32'h0000007F; in_pc = 32'h2008;
        @(posedge clk); #1;
        chk("b2b2 valid", {31'd0, out_valid}, 32'd1);
        chk("b2b2 illegal", {31'd0, out_illegal}, 32'd1);
        chk("b2b2 pc", out_pc, 32'h2008);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b drain valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a stall clears the slot and the register file at once.
        in_valid = 1'b1; in_instr = 32'h406283B3; in_pc = 32'h3000;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid-reset valid", {31'd0, out_valid}, 32'd0);
        chk("mid-reset l", out_l, 32'd0);
        chk("mid-reset rd", {27'd0, out_rd}, 32'd0);
        #3;
        rst = 1'b1; out_ready = 1'b1;
        in_instr = enc_r(7'h00, 5'd6, 5'd5, 3'd0, 5'd7); in_pc = 32'h3004;
        @(posedge clk); #1;
        chk("post-reset valid", {31'd0, out_valid}, 32'd1);
        chk("post-reset rf l", out_l, 32'd0);
        chk("post-reset rf r", out_r, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Issue stage directly upstream of the ALU: accepts one 32-bit RV32I(+MUL) instruction per handshake and decodes it.
- Reads an internal 32x32 register file, with bypass from the writeback port, and builds the ALU operands.
- Registers l_in, r_in and the 5-bit ALU control into one output pipeline slot with valid/ready flow control.
- Also owns the register-file write port used by writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_UNUSED, 0, reserved; must stay 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  address of in_instr
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  32  write data
- out_valid  out  1  issue slot holds an instruction
- out_ready  in  1  downstream ALU stage accepts
- out_l  out  32  ALU l_in
- out_r  out  32  ALU r_in
- out_ctrl  out  5  ALU control code
- out_rd  out  5  destination register
- out_rd_we  out  1  result must be written back
- out_branch  out  1  instruction is a conditional branch
- out_imm  out  32  sign-extended B-immediate (branches), else 0
- out_pc  out  32  pc of the issued instruction
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst=0, asynchronous): all out_* = 0, out_valid = 0. Register file cleared to 0.
- in_ready = !out_valid | out_ready (combinational).
- Accept when in_valid & in_ready. On the next edge the slot loads the decode result and out_valid = 1. Latency is one cycle.
- If out_valid & out_ready and no new accept, out_valid drops to 0. Outputs hold their values while out_valid & !out_ready.
- Register file:
  - x0 reads as 0; writes to x0 are ignored.
  - The write happens on the clock edge when wb_en = 1.
  - Bypass: if wb_en & wb_addr == rs & rs != 0 in the accept cycle, the operand uses wb_data.
  - Writeback has priority; it is never stalled.
- Decode (opcode -> ctrl, l, r):
  - OP 0110011:
    - funct7 = 0: funct3 000 ADD = 0, 111 AND = 2, 110 OR = 3, 100 XOR = 4, 001 SLL = 9, 101 SRL = 8, 010 SLT = 14, 011 SLTU = 16.
    - funct7 = 0100000: 000 SUB = 1, 101 SRA = 7.
    - funct7 = 0000001 with funct3 000: MUL = 10.
    - l = rs1, r = rs2, rd_we = 1.
  - OP-IMM 0010011: same funct3 map without SUB/MUL.
    - r = sign-extended I-imm.
    - For shifts r = {27'b0, instr[24:20]}. SRAI requires instr[31:25] = 0100000; SLLI/SRLI require 0.
  - LUI 0110111: ctrl = 11, l = 0, r = {12'b0, instr[31:12]}, rd_we = 1.
  - AUIPC 0010111: ctrl = 0, l = in_pc, r = {instr[31:12], 12'b0}, rd_we = 1.
  - BRANCH 1100011:
    - funct3 000 BEQ = 12, 001 BNE = 13, 100 BLT = 14, 101 BGE = 15, 110 BLTU = 16, 111 BGEU = 17.
    - l = rs1, r = rs2, rd_we = 0, out_branch = 1, out_imm = B-imm.
    - funct3 010/011 are illegal.
- Any other opcode or funct combination: out_illegal = 1, ctrl = 0, rd_we = 0, l = r = 0, out_branch = 0. It still occupies the slot for one handshake.
- out_rd = instr[11:7] when rd_we, else 0. If rd = x0, rd_we is still 1; writeback ignores it.
- Simultaneous accept and drain: the slot is replaced, out_valid stays 1, and no bubble is inserted.
- Reset asserted mid-operation discards the slot instance and clears all outputs immediately.
- No hazard detection beyond same-cycle bypass. Upstream must not issue a dependent instruction while the producer is in flight.

Test Plan:
- Reset then write wb x5 = 0x00000007, x6 = 0x00000003; issue SUB x7,x5,x6 (0x406283B3) -> next cycle out_valid = 1, ctrl = 1, l = 7, r = 3, rd = 7, rd_we = 1.
- Issue ADDI x1,x0,-1 (0xFFF00093) with wb_en = 1, wb_addr = 0 in the same cycle -> l = 0, r = 0xFFFFFFFF, ctrl = 0; x0 stays 0.
- Issue SRAI x2,x1,4 (0x4040D113) in the same cycle as wb x1 = 0x80000000 -> bypass gives l = 0x80000000, r = 4, ctrl = 7.
- LUI x3,0x12345 (0x123451B7) -> ctrl = 11, r = 0x00012345; AUIPC at pc 0x100 with imm 1 -> ctrl = 0, l = 0x100, r = 0x1000.
- BGE x1,x2,-8 (0xFE20DCE3) -> ctrl = 15, out_branch = 1, out_imm = 0xFFFFFFF8, rd_we = 0.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs stable. Raise out_ready -> a back-to-back accept with no bubble. Opcode 0x7F -> out_illegal = 1. Assert rst mid-stall -> out_valid = 0 immediately.
